// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA score display.
//   - 640x480 @ 60 Hz horizontal/vertical timing constants
//   - digit glyph geometry
//   - colour constants (12-bit {R,G,B})
//   - BCD engine state type
//   - seg_decode: BCD digit -> {a,b,c,d,e,f,g} segment enables
package vga_pkg;

  // Horizontal timing, in pixels
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int H_SYNC_START = H_VIS + H_FP;           // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;  // 752 (exclusive)
  localparam int V_SYNC_START = V_VIS + V_FP;           // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;  // 492 (exclusive)

  // Digit cell geometry: 4 cells of 64 px, glyph occupies the left 48 px
  localparam int NUM_DIGITS = 4;
  localparam int CELL_W     = 64;
  localparam int GLYPH_W    = 48;
  localparam int GLYPH_H    = 128;

  // Colours as {R,G,B}, 4 bits each
  localparam logic [11:0] COL_SEG   = 12'hFFF;
  localparam logic [11:0] COL_BG    = 12'h004;
  localparam logic [11:0] COL_BLANK = 12'h000;

  // Binary-to-BCD conversion width
  localparam int BIN_W      = 32;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    BCD_IDLE = 2'd0,
    BCD_BUSY = 2'd1,
    BCD_DONE = 2'd2
  } bcd_state_e;

  // Standard 7-segment map, bit order {a,b,c,d,e,f,g}.
  // Non-BCD codes light nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vga_controller_score_bcd.sv
// score_bcd: sequential double-dabble converter, 32-bit binary -> 10 BCD digits.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset; aborts a conversion in flight
//   start_i  : 1-clk start pulse; ignored unless idle
//   bin_i    : binary value sampled on start
//   busy_o   : high for exactly 32 clks while bits are shifted in
//   done_o   : 1-clk pulse; bcd_o is valid on that clk (and held until next start)
//   bcd_o    : 10 BCD digits, least significant digit in bits [3:0]
//   state_o  : FSM state, for observation
//
// Handshake: start_i is accepted only when state_o == BCD_IDLE; the result is
// presented with a single-cycle done_o, and there is no back-pressure.
module score_bcd
  import vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o,
  output bcd_state_e        state_o
);

  bcd_state_e       state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       cnt_q;

  // Add-3 correction on every digit >= 5 before each shift, so the digit
  // carries correctly into its neighbour when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= BCD_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        BCD_IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= BCD_BUSY;
          end
        end
        BCD_BUSY: begin
          // One binary bit enters the BCD register per clock, MSB first.
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(BIN_W - 1)) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= BCD_DONE;
          end
        end
        BCD_DONE: begin
          state_q <= BCD_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= BCD_IDLE;
        end
      endcase
    end
  end

  assign bcd_o   = bcd_q;
  assign state_o = state_q;

endmodule

// File: rtl/vga_controller.sv
// vga_controller: 640x480 @ 60 Hz VGA timing plus a 4-digit 7-segment score.
//   clk       : 100 MHz system clock
//   reset     : synchronous active-high reset
//   score     : 32-bit unsigned score from the game logic
//   hSync     : horizontal sync, active low
//   vSync     : vertical sync, active low
//   VGA_R/G/B : 4-bit colour channels
//   ps2_clk   : reserved, released (Z)
//   ps2_data  : reserved, released (Z)
//
// The score is sampled once per frame at the start of vertical blanking and
// converted to BCD; the lowest four digits (score mod 10000) are shown until
// the next frame's conversion completes.
module vga_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DIG_X0  = 192,
  parameter int DIG_Y0  = 176,
  parameter int SEG_T   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  inout  wire         ps2_clk,
  inout  wire         ps2_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Pixel-rate counters
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             pe;

  // Registered pixel outputs
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;

  // Displayed digits, thousands digit in [15:12]
  logic [15:0] digits_q;

  // BCD engine interface
  logic             bcd_start;
  logic             bcd_done;
  logic             bcd_busy_unused;
  logic [BCD_W-1:0] bcd_val;
  logic [BCD_W-17:0] bcd_high_unused;
  bcd_state_e       bcd_state;

  // Pixel geometry scratch
  int         cell_x, cell_y, lx, ly;
  logic       visible, in_cell, in_glyph, lit;
  logic [3:0] cur_digit;
  logic [6:0] seg;
  logic       hit_a, hit_b, hit_c, hit_d, hit_e, hit_f, hit_g;

  // ---------------------------------------------------------------------------
  // Pixel enable and raster counters
  // ---------------------------------------------------------------------------
  assign pe = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d    = pe ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pe) begin
      if (hcount_q == 10'(H_TOT - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == 10'(V_TOT - 1)) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel colour and sync for the current (hcount, vcount)
  // ---------------------------------------------------------------------------
  always_comb begin
    visible = (int'(hcount_q) < H_VIS) && (int'(vcount_q) < V_VIS);
    hsync_d = !((int'(hcount_q) >= H_SYNC_START) && (int'(hcount_q) < H_SYNC_END));
    vsync_d = !((int'(vcount_q) >= V_SYNC_START) && (int'(vcount_q) < V_SYNC_END));

    cell_x   = int'(hcount_q) - DIG_X0;
    cell_y   = int'(vcount_q) - DIG_Y0;
    lx       = cell_x & (CELL_W - 1);
    ly       = cell_y;
    in_cell  = (cell_x >= 0) && (cell_x < NUM_DIGITS * CELL_W) &&
               (cell_y >= 0) && (cell_y < GLYPH_H);
    in_glyph = in_cell && (lx < GLYPH_W);

    // Cell index: 0 is the leftmost (thousands) digit.
    case (cell_x[7:6])
      2'd0:    cur_digit = digits_q[15:12];
      2'd1:    cur_digit = digits_q[11:8];
      2'd2:    cur_digit = digits_q[7:4];
      default: cur_digit = digits_q[3:0];
    endcase
    seg = seg_decode(cur_digit);

    hit_a = (ly < SEG_T);
    hit_b = (lx >= GLYPH_W - SEG_T) && (ly < GLYPH_H / 2);
    hit_c = (lx >= GLYPH_W - SEG_T) && (ly >= GLYPH_H / 2);
    hit_d = (ly >= GLYPH_H - SEG_T);
    hit_e = (lx < SEG_T) && (ly >= GLYPH_H / 2);
    hit_f = (lx < SEG_T) && (ly < GLYPH_H / 2);
    // g straddles the vertical centre of the glyph
    hit_g = (ly >= GLYPH_H / 2 - SEG_T / 2) && (ly < GLYPH_H / 2 + SEG_T / 2);

    lit = (seg[6] & hit_a) | (seg[5] & hit_b) | (seg[4] & hit_c) |
          (seg[3] & hit_d) | (seg[2] & hit_e) | (seg[1] & hit_f) |
          (seg[0] & hit_g);

    if (!visible) begin
      rgb_d = COL_BLANK;
    end else if (in_glyph && lit) begin
      rgb_d = COL_SEG;
    end else begin
      rgb_d = COL_BG;
    end
  end

  // Syncs and colour share one register stage on pe so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= COL_BLANK;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      if (pe) begin
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        rgb_q   <= rgb_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Score capture: sample at the first blank line, show after conversion
  // ---------------------------------------------------------------------------
  assign bcd_start = pe && (hcount_q == '0) && (vcount_q == 10'(V_VIS)) &&
                     (bcd_state == BCD_IDLE);

  score_bcd u_score_bcd (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (bcd_start),
    .bin_i   (score),
    .busy_o  (bcd_busy_unused),
    .done_o  (bcd_done),
    .bcd_o   (bcd_val),
    .state_o (bcd_state)
  );

  assign bcd_high_unused = bcd_val[BCD_W-1:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
    end else if (bcd_done) begin
      digits_q <= bcd_val[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hSync = hsync_q;
  assign vSync = vsync_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

endmodule

// File: tb/tb_vga_controller.sv
// Testbench for vga_controller: directed checks of reset state, sync timing,
// blanking, digit rendering and frame-boundary score capture.
module tb_vga_controller;

  localparam int CPP       = 4;       // clocks per pixel
  localparam int FRAME_PIX = 420000;  // 800 x 525

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] score;
  logic        hSync, vSync;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [11:0] rgb;
  wire         ps2_clk_w;
  wire         ps2_data_w;

  // Opposite pulls: a released line reads as its pull value.
  pullup   (ps2_clk_w);
  pulldown (ps2_data_w);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int vs_fall0;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_controller dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .hSync    (hSync),
    .vSync    (vSync),
    .VGA_R    (vga_r),
    .VGA_G    (vga_g),
    .VGA_B    (vga_b),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset-relative cycle counter
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // cyc = number of rising edges seen with reset low.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------------
  // Driver / timing tasks
  // ---------------------------------------------------------------------------
  // Pixel n is registered on pe number n, i.e. on edge CPP*(n+1), and is held
  // for CPP clocks; sample it on the following falling edge.
  task automatic goto_pix(input int frame, input int x, input int y);
    int target;
    target = CPP * (frame * FRAME_PIX + y * 800 + x + 1);
    n_checks++;
    if (cyc > target) begin
      n_fail++;
      $display("FAIL schedule: at cyc %0d, required cyc <= %0d for pixel (%0d,%0d)",
               cyc, target, x, y);
    end
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_hs(input logic lvl, input int bound, output int t);
    int k;
    k = 0;
    t = -1;
    while (hSync !== lvl && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (hSync === lvl) t = cyc;
  endtask

  task automatic wait_vs(input logic lvl, input int bound, output int t);
    int k;
    k = 0;
    t = -1;
    while (vSync !== lvl && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (vSync === lvl) t = cyc;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    score = 32'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (hSync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", hSync); end
    n_checks++;
    if (vSync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vSync); end
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    n_checks++;
    if (ps2_clk_w !== 1'b1) begin n_fail++; $display("FAIL reset_ps2_clk: got %b expected released", ps2_clk_w); end
    n_checks++;
    if (ps2_data_w !== 1'b0) begin n_fail++; $display("FAIL reset_ps2_data: got %b expected released", ps2_data_w); end
    reset = 1'b0;
  endtask

  task automatic test_hsync_timing;
    int t_fall, t_rise, t_fall2;
    wait_hs(1'b0, 5000, t_fall);
    // hcount 656 is reached on pe number 656, which lands on edge 4*657 = 2628;
    // accept the 656*4 +/- one pixel window.
    n_checks++;
    if (t_fall < 2620 || t_fall > 2628) begin
      n_fail++;
      $display("FAIL hsync_first_fall: got cyc %0d expected 2620..2628", t_fall);
    end
    wait_hs(1'b1, 5000, t_rise);
    n_checks++;
    if (t_rise - t_fall !== 384) begin
      n_fail++;
      $display("FAIL hsync_low_width: got %0d expected 384", t_rise - t_fall);
    end
    wait_hs(1'b0, 5000, t_fall2);
    n_checks++;
    if (t_fall2 - t_fall !== 3200) begin
      n_fail++;
      $display("FAIL hsync_period: got %0d expected 3200", t_fall2 - t_fall);
    end
    // Line 3: last visible pixel is background, blanking is black.
    goto_pix(0, 639, 3);
    n_checks++;
    if (rgb !== 12'h004) begin n_fail++; $display("FAIL vis_edge_639: got %h expected 004", rgb); end
    goto_pix(0, 645, 3);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL hblank_645: got %h expected 000", rgb); end
    goto_pix(0, 700, 3);
    n_checks++;
    if (rgb !== 12'h000 || hSync !== 1'b0) begin
      n_fail++;
      $display("FAIL hsync_region_700: got rgb %h hs %b expected rgb 000 hs 0", rgb, hSync);
    end
    goto_pix(0, 799, 3);
    n_checks++;
    if (rgb !== 12'h000 || hSync !== 1'b1) begin
      n_fail++;
      $display("FAIL hbp_799: got rgb %h hs %b expected rgb 000 hs 1", rgb, hSync);
    end
  endtask

  // Frame 0 shows the reset digits 0000.
  task automatic test_score_zero;
    int px[5]       = '{192, 256, 216, 192, 216};
    int py[5]       = '{176, 176, 236, 240, 240};
    logic [11:0] ex[5] = '{12'hFFF, 12'hFFF, 12'h004, 12'hFFF, 12'h004};
    for (int i = 0; i < 5; i++) begin
      goto_pix(0, px[i], py[i]);
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++;
        $display("FAIL zero_pix(%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex[i]);
      end
    end
    score = 32'd1234;
  endtask

  task automatic test_vsync_first;
    int t_rise;
    goto_pix(0, 320, 479);
    n_checks++;
    if (rgb !== 12'h004) begin n_fail++; $display("FAIL last_vis_line: got %h expected 004", rgb); end
    goto_pix(0, 100, 480);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL vblank_480: got %h expected 000", rgb); end
    wait_vs(1'b0, 400000, vs_fall0);
    // vcount 490, hcount 0 is pe number 392000 -> edge 4*392001.
    n_checks++;
    if (vs_fall0 !== 1568004) begin
      n_fail++;
      $display("FAIL vsync_first_fall: got cyc %0d expected 1568004", vs_fall0);
    end
    wait_vs(1'b1, 20000, t_rise);
    n_checks++;
    if (t_rise - vs_fall0 !== 6400) begin
      n_fail++;
      $display("FAIL vsync_low_width: got %0d expected 6400", t_rise - vs_fall0);
    end
  endtask

  // Frame 1 shows 1234.
  task automatic test_score_1234;
    int px[6]       = '{192, 260, 400, 232, 256, 400};
    int py[6]       = '{176, 176, 176, 200, 200, 240};
    logic [11:0] ex[6] = '{12'h004, 12'hFFF, 12'h004, 12'hFFF, 12'h004, 12'hFFF};
    for (int i = 0; i < 6; i++) begin
      goto_pix(1, px[i], py[i]);
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++;
        $display("FAIL s1234_pix(%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex[i]);
      end
    end
    score = 32'd5;
  endtask

  task automatic test_vsync_period;
    int t_fall;
    wait_vs(1'b0, 2000000, t_fall);
    n_checks++;
    if (t_fall - vs_fall0 !== 1680000) begin
      n_fail++;
      $display("FAIL vsync_period: got %0d expected 1680000", t_fall - vs_fall0);
    end
  endtask

  // Frame 2 latched 5; a change at line 100 must not show until frame 3.
  task automatic test_mid_frame;
    int px[4]        = '{192, 384, 424, 408};
    int py[4]        = '{176, 200, 200, 300};
    logic [11:0] ex5[4] = '{12'hFFF, 12'hFFF, 12'h004, 12'hFFF};
    logic [11:0] ex7[4] = '{12'hFFF, 12'h004, 12'hFFF, 12'h004};
    goto_pix(2, 0, 100);
    score = 32'd7;
    for (int i = 0; i < 4; i++) begin
      goto_pix(2, px[i], py[i]);
      n_checks++;
      if (rgb !== ex5[i]) begin
        n_fail++;
        $display("FAIL mid_frame_5(%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex5[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      goto_pix(3, px[i], py[i]);
      n_checks++;
      if (rgb !== ex7[i]) begin
        n_fail++;
        $display("FAIL next_frame_7(%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex7[i]);
      end
    end
    score = 32'd12345;
  endtask

  // Frame 4 shows 12345 mod 10000 = 2345.
  task automatic test_wrap;
    int px[8]       = '{192, 192, 232, 256, 384, 424, 192, 256};
    int py[8]       = '{176, 200, 200, 200, 200, 200, 260, 260};
    logic [11:0] ex[8] = '{12'hFFF, 12'h004, 12'hFFF, 12'h004,
                           12'hFFF, 12'h004, 12'hFFF, 12'h004};
    for (int i = 0; i < 8; i++) begin
      goto_pix(4, px[i], py[i]);
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++;
        $display("FAIL wrap_pix(%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex[i]);
      end
    end
    n_checks++;
    if (ps2_clk_w !== 1'b1) begin n_fail++; $display("FAIL end_ps2_clk: got %b expected released", ps2_clk_w); end
    n_checks++;
    if (ps2_data_w !== 1'b0) begin n_fail++; $display("FAIL end_ps2_data: got %b expected released", ps2_data_w); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    score = 32'd0;
    test_reset();
    test_hsync_timing();
    test_score_zero();
    test_vsync_first();
    test_score_1234();
    test_vsync_period();
    test_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
